// File: rtl/junction_sequencer_if.sv
// Signal bundle between the junction sequencer, its timing source, the adaptation
// block and the lamp drivers.
interface junction_sequencer_if;
    logic       tick;
    logic [7:0] TGn;
    logic [7:0] TGe;
    logic [7:0] TGs;
    logic [7:0] TGw;
    logic [7:0] N_n;
    logic [7:0] N_e;
    logic [7:0] N_s;
    logic [7:0] N_w;
    logic       emg_req;
    logic [1:0] emg_road;
    logic [1:0] next_road;
    logic [1:0] light_n;
    logic [1:0] light_e;
    logic [1:0] light_s;
    logic [1:0] light_w;
    logic [7:0] remaining;

    modport master (
        output tick, TGn, TGe, TGs, TGw, N_n, N_e, N_s, N_w, emg_req, emg_road,
        input  next_road, light_n, light_e, light_s, light_w, remaining
    );

    modport slave (
        input  tick, TGn, TGe, TGs, TGw, N_n, N_e, N_s, N_w, emg_req, emg_road,
        output next_road, light_n, light_e, light_s, light_w, remaining
    );
endinterface

// File: rtl/junction_sequencer.sv
// Four-road junction sequencer: ALL_RED -> GREEN -> YELLOW per road, with emergency pre-emption.
// Optional SKIP_EMPTY_EN: the successor road skips roads whose queued-vehicle count is zero.
module junction_sequencer #(
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 1
) (
    input logic                 clk,
    input logic                 reset,
    junction_sequencer_if.slave bus
);
    localparam int unsigned CW = 8;
    localparam int unsigned RW = 2;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] cur, cur_nxt;
    logic [RW-1:0] succ;
    logic [RW-1:0] road_go;
    logic [RW-1:0] emg_tgt, tgt_nxt;
    logic          emg_pend, pend_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          phase_end, phase_dec;
    logic [7:0]    lamps, lamps_nxt;
    logic [CW-1:0] tg [4];

    always_comb begin
        tg[0] = bus.TGn;
        tg[1] = bus.TGe;
        tg[2] = bus.TGs;
        tg[3] = bus.TGw;
    end

`ifdef SKIP_EMPTY_EN
    logic [CW-1:0] queue_len [4];

    always_comb begin
        queue_len[0] = bus.N_n;
        queue_len[1] = bus.N_e;
        queue_len[2] = bus.N_s;
        queue_len[3] = bus.N_w;
    end

    // Nearest occupied road after cur wins; plain rotation when nothing is queued elsewhere.
    always_comb begin
        succ = RW'(cur + RW'(1));
        for (int k = 3; k >= 1; k--) begin
            if (queue_len[RW'(cur + RW'(k))] != '0) begin
                succ = RW'(cur + RW'(k));
            end
        end
    end
`else
    always_comb begin
        succ = RW'(cur + RW'(1));
    end
`endif

    // Next-state logic; an emergency target is latched so a one-cycle request is not lost.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        cnt_nxt   = cnt;
        pend_nxt  = emg_pend;
        tgt_nxt   = emg_tgt;
        road_go   = cur;
        phase_end = bus.tick && (cnt == CW'(1));
        phase_dec = bus.tick && (cnt > CW'(1));

        case (state)
            ALL_RED: begin
                if (bus.emg_req) begin
                    pend_nxt = 1'b1;
                    tgt_nxt  = bus.emg_road;
                end
                if (phase_end) begin
                    road_go   = bus.emg_req ? bus.emg_road : (emg_pend ? emg_tgt : cur);
                    state_nxt = GREEN;
                    cur_nxt   = road_go;
                    cnt_nxt   = (tg[road_go] == '0) ? CW'(1) : tg[road_go];
                    pend_nxt  = 1'b0;
                end else if (phase_dec) begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            GREEN: begin
                if (bus.emg_req && (bus.emg_road != cur)) begin
                    state_nxt = YELLOW;
                    cnt_nxt   = CW'(YELLOW_T);
                    pend_nxt  = 1'b1;
                    tgt_nxt   = bus.emg_road;
                end else if (bus.emg_req) begin
                    cnt_nxt = cnt;
                end else if (phase_end) begin
                    state_nxt = YELLOW;
                    cnt_nxt   = CW'(YELLOW_T);
                end else if (phase_dec) begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            YELLOW: begin
                if (bus.emg_req) begin
                    pend_nxt = 1'b1;
                    tgt_nxt  = bus.emg_road;
                end
                if (phase_end) begin
                    road_go   = bus.emg_req ? bus.emg_road : (emg_pend ? emg_tgt : succ);
                    state_nxt = ALL_RED;
                    cur_nxt   = road_go;
                    cnt_nxt   = CW'(ALLRED_T);
                    pend_nxt  = 1'b0;
                end else if (phase_dec) begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = ALL_RED;
                cur_nxt   = '0;
                cnt_nxt   = CW'(ALLRED_T);
                pend_nxt  = 1'b0;
                tgt_nxt   = '0;
            end
        endcase
    end

    // Lamp codes decoded from the upcoming state so the lamp flops track the phase exactly.
    always_comb begin
        lamps_nxt = '0;
        if (state_nxt == GREEN) begin
            lamps_nxt[{cur_nxt, 1'b0} +: 2] = 2'b10;
        end else if (state_nxt == YELLOW) begin
            lamps_nxt[{cur_nxt, 1'b0} +: 2] = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ALL_RED;
            cur      <= '0;
            cnt      <= CW'(ALLRED_T);
            emg_pend <= 1'b0;
            emg_tgt  <= '0;
            lamps    <= '0;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            cnt      <= cnt_nxt;
            emg_pend <= pend_nxt;
            emg_tgt  <= tgt_nxt;
            lamps    <= lamps_nxt;
        end
    end

    assign bus.next_road = cur;
    assign bus.remaining = cnt;
    assign bus.light_n   = lamps[1:0];
    assign bus.light_e   = lamps[3:2];
    assign bus.light_s   = lamps[5:4];
    assign bus.light_w   = lamps[7:6];
endmodule

// File: tb/tb_junction_sequencer.sv
// Self-checking bench for junction_sequencer: vector table, directed corner sequences,
// and randomized traffic checked against a phase-level reference model.
module tb_junction_sequencer;
    localparam int unsigned YT = 3;
    localparam int unsigned AT = 1;
    localparam int PH_RED = 0;
    localparam int PH_GRN = 1;
    localparam int PH_YEL = 2;

    logic clk;
    logic reset;
    junction_sequencer_if bus ();

    junction_sequencer #(.YELLOW_T(YT), .ALLRED_T(AT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int tg [4];
    int ncnt [4];

    // Reference model: which phase is lit, for which road, and how many ticks remain.
    int m_phase;
    int m_road;
    int m_left;
    int m_tgt;
    bit m_pend;

    typedef struct {
        bit         tk;
        bit         er;
        int         eroad;
        logic [1:0] nr;
        logic [7:0] lamps;
        logic [7:0] rem;
    } vec_t;

    vec_t tbl [22];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] act_lamps();
        return {bus.light_w, bus.light_s, bus.light_e, bus.light_n};
    endfunction

    function automatic logic [7:0] model_lamps();
        int code;
        code = (m_phase == PH_GRN) ? 2 : ((m_phase == PH_YEL) ? 1 : 0);
        return 8'(code << (2 * m_road));
    endfunction

    function automatic int following_road(int r);
`ifdef SKIP_EMPTY_EN
        for (int k = 1; k <= 3; k++) begin
            if (ncnt[(r + k) % 4] != 0) return (r + k) % 4;
        end
`endif
        return (r + 1) % 4;
    endfunction

    task automatic model_step(bit tk, bit er, int eroad);
        bit ends;
        ends = tk && (m_left == 1);
        if (m_phase == PH_RED) begin
            if (er) begin m_pend = 1'b1; m_tgt = eroad; end
            if (ends) begin
                if (m_pend) m_road = m_tgt;
                m_pend  = 1'b0;
                m_phase = PH_GRN;
                m_left  = (tg[m_road] == 0) ? 1 : tg[m_road];
            end else if (tk) m_left--;
        end else if (m_phase == PH_GRN) begin
            if (er && eroad != m_road) begin
                m_phase = PH_YEL; m_left = YT; m_pend = 1'b1; m_tgt = eroad;
            end else if (er) begin
                m_left = m_left;
            end else if (ends) begin
                m_phase = PH_YEL; m_left = YT;
            end else if (tk) m_left--;
        end else begin
            if (er) begin m_pend = 1'b1; m_tgt = eroad; end
            if (ends) begin
                m_road  = m_pend ? m_tgt : following_road(m_road);
                m_pend  = 1'b0;
                m_phase = PH_RED;
                m_left  = AT;
            end else if (tk) m_left--;
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, compare after it.
    task automatic step(bit tk, bit er, int eroad);
        logic [17:0] act_v;
        logic [17:0] exp_v;
        @(negedge clk);
        bus.tick = tk;  bus.emg_req = er;  bus.emg_road = 2'(eroad);
        bus.TGn = 8'(tg[0]);  bus.TGe = 8'(tg[1]);  bus.TGs = 8'(tg[2]);  bus.TGw = 8'(tg[3]);
        bus.N_n = 8'(ncnt[0]); bus.N_e = 8'(ncnt[1]); bus.N_s = 8'(ncnt[2]); bus.N_w = 8'(ncnt[3]);
        @(posedge clk);
        model_step(tk, er, eroad);
        #1;
        act_v = {bus.next_road, act_lamps(), bus.remaining};
        exp_v = {2'(m_road), model_lamps(), 8'(m_left)};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL model_cycle actual nr=%0d lamps=%h rem=%0d required nr=%0d lamps=%h rem=%0d",
                     act_v[17:16], act_v[15:8], act_v[7:0], exp_v[17:16], exp_v[15:8], exp_v[7:0]);
        end
    endtask

    // Reset is asserted between clock edges so the forced outputs are checked asynchronously.
    task automatic do_reset();
        @(negedge clk);
        bus.tick = 1'b0; bus.emg_req = 1'b0; bus.emg_road = 2'd0;
        #2;
        reset = 1'b0;
        #1;
        check("reset_next_road", int'(bus.next_road), 0);
        check("reset_lamps", int'(act_lamps()), 0);
        check("reset_remaining", int'(bus.remaining), AT);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_phase = PH_RED; m_road = 0; m_left = AT; m_pend = 1'b0; m_tgt = 0;
    endtask

    function automatic vec_t row(bit tk, bit er, int eroad, int nr, int lamps, int rem);
        vec_t v;
        v.tk = tk; v.er = er; v.eroad = eroad;
        v.nr = 2'(nr); v.lamps = 8'(lamps); v.rem = 8'(rem);
        return v;
    endfunction

    initial begin
        bit found;
        int hold;
        int hroad;
        reset = 1'b0;
        bus.tick = 1'b0; bus.emg_req = 1'b0; bus.emg_road = 2'd0;
        for (int r = 0; r < 4; r++) begin tg[r] = 10; ncnt[r] = 5; end

        // Vector table: all greens 10, tick every cycle, then holds and a pre-emption.
        tbl[0] = row(1, 0, 0, 0, 'h02, 10);
        for (int i = 1; i <= 9; i++) tbl[i] = row(1, 0, 0, 0, 'h02, 10 - i);
        tbl[10] = row(1, 0, 0, 0, 'h01, 3);
        tbl[11] = row(1, 0, 0, 0, 'h01, 2);
        tbl[12] = row(1, 0, 0, 0, 'h01, 1);
        tbl[13] = row(1, 0, 0, 1, 'h00, 1);
        tbl[14] = row(1, 0, 0, 1, 'h08, 10);
        tbl[15] = row(0, 0, 0, 1, 'h08, 10);
        tbl[16] = row(1, 1, 1, 1, 'h08, 10);
        tbl[17] = row(0, 1, 3, 1, 'h04, 3);
        tbl[18] = row(1, 0, 0, 1, 'h04, 2);
        tbl[19] = row(1, 0, 0, 1, 'h04, 1);
        tbl[20] = row(1, 0, 0, 3, 'h00, 1);
        tbl[21] = row(1, 0, 0, 3, 'h80, 10);

        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].tk, tbl[i].er, tbl[i].eroad);
            check($sformatf("table_row%0d", i),
                  int'({bus.next_road, act_lamps(), bus.remaining}),
                  int'({tbl[i].nr, tbl[i].lamps, tbl[i].rem}));
        end

        // Zero green duration still gives east one tick of green.
        tg = '{2, 0, 2, 2};
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        check("tg0_east_green_lamps", int'(act_lamps()), 'h08);
        check("tg0_east_green_rem", int'(bus.remaining), 1);
        step(1, 0, 0);
        check("tg0_east_yellow_after_one_tick", int'(act_lamps()), 'h04);

        // Pre-emption to south during north green at 7 ticks left; east is skipped.
        tg = '{10, 10, 10, 10};
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        check("emg_north_rem7", int'(bus.remaining), 7);
        step(0, 1, 2);
        check("emg_north_yellow", int'(bus.light_n), 1);
        check("emg_yellow_rem", int'(bus.remaining), YT);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        check("emg_allred_next_road", int'(bus.next_road), 2);
        check("emg_allred_lamps", int'(act_lamps()), 0);
        step(1, 0, 0);
        check("emg_south_green", int'(act_lamps()), 'h20);

        // Request for the road already green freezes the countdown.
        for (int i = 0; i < 20; i++) step(1, 1, 2);
        check("emg_hold_rem", int'(bus.remaining), 10);
        check("emg_hold_lamps", int'(act_lamps()), 'h20);
        step(1, 0, 0);
        check("emg_release_rem", int'(bus.remaining), 9);

        // Reset mid west-yellow, then a restart from north.
        tg = '{2, 2, 2, 2};
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1, 0, 0);
            if (m_phase == PH_YEL && m_road == 3) found = 1'b1;
        end
        check("reach_west_yellow", int'(found), 1);
        check("west_yellow_lamps", int'(act_lamps()), 'h40);
        do_reset();
        step(1, 0, 0);
        check("restart_north_green", int'({bus.next_road, act_lamps()}), 'h002);

`ifdef SKIP_EMPTY_EN
        ncnt = '{5, 0, 5, 5};
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        check("skip_empty_east", int'(bus.next_road), 2);
        ncnt = '{0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        check("skip_all_empty", int'(bus.next_road), 1);
`endif

        // Randomized traffic against the model.
        do_reset();
        hold = 0;
        hroad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int r = 0; r < 4; r++) begin
                    tg[r]   = $urandom_range(0, 12);
                    ncnt[r] = $urandom_range(0, 2);
                end
            end
            if (hold == 0 && $urandom_range(0, 39) == 0) begin
                hold  = $urandom_range(1, 8);
                hroad = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                hold = 0;
            end
            step(1'($urandom_range(0, 1)), hold != 0, hroad);
            if (hold != 0) hold--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
